// File: rtl/ips2l_uart_status_pkg.sv
// ips2l_uart_status_pkg: shared state encoding, address field layout and default error word
package ips2l_uart_status_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_e;
   localparam int IDX_MSB = 7;
   localparam int IDX_LSB = 4;
   localparam int OFS_MSB = 3;
   localparam int OFS_LSB = 0;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/ips2l_status_rd_timer.sv
// ips2l_status_rd_timer: 16-bit clear/enable up-counter; tc_o flags the cycle whose count equals term_i
module ips2l_status_rd_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [15:0] term_i,
   output logic        tc_o
);
   logic [15:0] cnt_q;
   always_ff @(posedge clk) begin
      if (rst || clr_i) cnt_q <= '0;
      else if (en_i) cnt_q <= cnt_q + 16'd1;
   end
   // cnt_q holds completed cycles, so the current cycle's count is cnt_q + 1
   assign tc_o = en_i && (cnt_q + 16'd1 == term_i);
endmodule

// File: rtl/ips2l_uart_status_rd_ctrl.sv
// ips2l_uart_status_rd_ctrl: decodes UART status reads into per-source req/ack transactions.
// Define IPS2L_UART_STATUS_TIMEOUT_EN to abandon reads after TIMEOUT_CYC WAIT cycles.
module ips2l_uart_status_rd_ctrl
   import ips2l_uart_status_pkg::*;
#(
   parameter int          NUM_SRC     = 4,
   parameter logic [15:0] TIMEOUT_CYC = 16'd1023,
   parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_req,
   input  logic [7:0]            uart_rd_addr,
   output logic                  read_ack,
   output logic [31:0]           status_bus,
   output logic [NUM_SRC-1:0]    src_req,
   output logic [3:0]            src_addr,
   input  logic [NUM_SRC-1:0]    src_ack,
   input  logic [NUM_SRC*32-1:0] src_data,
   output logic [7:0]            err_cnt
);
   state_e               state_q, state_d;
   logic [NUM_SRC-1:0]   src_req_q, src_req_d;
   logic [3:0]           src_addr_q, src_addr_d;
   logic                 read_ack_q, read_ack_d;
   logic [31:0]          status_q, status_d;
   logic [7:0]           err_q, err_d;
   logic [31:0]          sel_data;
   logic                 ack_hit, tmo, err_evt;

`ifdef IPS2L_UART_STATUS_TIMEOUT_EN
   ips2l_status_rd_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (state_q != WAIT),
      .en_i   (state_q == WAIT),
      .term_i (TIMEOUT_CYC),
      .tc_o   (tmo)
   );
`else
   assign tmo = 1'b0 & (TIMEOUT_CYC != 16'd0);
`endif

   // src_req_q is one-hot on the selected source during WAIT, masking foreign acks
   assign ack_hit = |(src_ack & src_req_q);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (src_req_q[i]) sel_data = src_data[32*i +: 32];
   end

   always_comb begin
      state_d    = state_q;
      src_req_d  = src_req_q;
      src_addr_d = src_addr_q;
      read_ack_d = 1'b0;
      status_d   = status_q;
      err_evt    = 1'b0;
      case (state_q)
         IDLE: if (read_req) begin
            src_addr_d = uart_rd_addr[OFS_MSB:OFS_LSB];
            if (int'(uart_rd_addr[IDX_MSB:IDX_LSB]) < NUM_SRC) begin
               state_d   = WAIT;
               src_req_d = NUM_SRC'(1) << uart_rd_addr[IDX_MSB:IDX_LSB];
            end else begin
               state_d    = RESP;
               read_ack_d = 1'b1;
               status_d   = ERR_DATA;
               err_evt    = 1'b1;
            end
         end
         WAIT: if (ack_hit || tmo) begin
            state_d    = RESP;
            read_ack_d = 1'b1;
            src_req_d  = '0;
            status_d   = ack_hit ? sel_data : ERR_DATA;
            err_evt    = !ack_hit;
         end
         RESP: state_d = HOLD;
         default: state_d = read_req ? HOLD : IDLE;
      endcase
      err_d = (err_evt && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         src_req_q  <= '0;
         src_addr_q <= '0;
         read_ack_q <= 1'b0;
         status_q   <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         src_req_q  <= src_req_d;
         src_addr_q <= src_addr_d;
         read_ack_q <= read_ack_d;
         status_q   <= status_d;
         err_q      <= err_d;
      end
   end

   assign read_ack   = read_ack_q;
   assign status_bus = status_q;
   assign src_req    = src_req_q;
   assign src_addr   = src_addr_q;
   assign err_cnt    = err_q;
endmodule

// File: tb/tb_ips2l_uart_status_rd_ctrl.sv
// tb_ips2l_uart_status_rd_ctrl: scoreboard bench; expected words queued at request, popped on read_ack
module tb_ips2l_uart_status_rd_ctrl;
   localparam int NS = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            read_req = 1'b0;
   logic [7:0]      uart_rd_addr = '0;
   logic            read_ack;
   logic [31:0]     status_bus;
   logic [NS-1:0]   src_req;
   logic [3:0]      src_addr;
   logic [NS-1:0]   src_ack;
   logic [NS*32-1:0] src_data;
   logic [7:0]      err_cnt;

   logic [31:0]     src_word [NS];
   logic [NS-1:0]   ack_en = '1;
   logic [NS-1:0]   extra_ack = '0;
   logic [NS-1:0]   model_ack;
   int              ack_dly [NS];
   int              req_cyc [NS];

   typedef struct {logic [31:0] data; logic [7:0] err;} exp_t;
   exp_t exp_q [$];
   int   model_err = 0;
   int   errors = 0;
   int   checks = 0;

   ips2l_uart_status_rd_ctrl #(.NUM_SRC(NS), .TIMEOUT_CYC(16'd8)) dut (
      .clk          (clk),
      .rst          (rst),
      .read_req     (read_req),
      .uart_rd_addr (uart_rd_addr),
      .read_ack     (read_ack),
      .status_bus   (status_bus),
      .src_req      (src_req),
      .src_addr     (src_addr),
      .src_ack      (src_ack),
      .src_data     (src_data),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   // source model: source i acks ack_dly[i] cycles after its src_req rises
   always @(posedge clk)
      for (int i = 0; i < NS; i++) req_cyc[i] <= src_req[i] ? req_cyc[i] + 1 : 0;

   always_comb begin
      model_ack = '0;
      for (int i = 0; i < NS; i++)
         model_ack[i] = src_req[i] & ack_en[i] & (req_cyc[i] == ack_dly[i]);
   end

   assign src_ack  = model_ack | extra_ack;
   assign src_data = {src_word[3], src_word[2], src_word[1], src_word[0]};

   always @(negedge clk) begin
      if (read_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: read_ack=1 with no request outstanding at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (status_bus !== e.data) begin
               errors++;
               $display("FAIL status_bus: got %h want %h at %0t", status_bus, e.data, $time);
            end
            checks++;
            if (err_cnt !== e.err) begin
               errors++;
               $display("FAIL err_cnt: got %h want %h at %0t", err_cnt, e.err, $time);
            end
         end
      end
   end

   task automatic bump_err();
      model_err = (model_err == 255) ? 255 : model_err + 1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; read_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_err = 0;
   endtask

   task automatic do_read(input logic [7:0] addr, input logic [NS-1:0] exp_req, input int exp_lat,
                          input logic [31:0] exp_data, input int hold, input string nm);
      int lat, extra;
      logic [3:0] sa;
      logic [NS-1:0] sr;
      logic [3:0] ofs;
      ofs = addr[3:0];
      exp_q.push_back('{exp_data, 8'(model_err)});
      uart_rd_addr = addr; read_req = 1'b1; lat = 0;
      do begin
         @(posedge clk); #1; lat++;
         if (lat == 1) begin sr = src_req; sa = src_addr; end
      end while (read_ack !== 1'b1 && lat < 2000);
      if (read_ack !== 1'b1) exp_q.delete();
      checks++;
      if (lat != exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
      end
      checks++;
      if (sr !== exp_req) begin
         errors++; $display("FAIL %s src_req cycle1: got %b want %b", nm, sr, exp_req);
      end
      if (exp_req != '0) begin
         checks++;
         if (sa !== ofs) begin
            errors++; $display("FAIL %s src_addr: got %h want %h", nm, sa, ofs);
         end
      end
      checks++;
      if (src_req !== '0) begin
         errors++; $display("FAIL %s src_req at ack: got %b want 0", nm, src_req);
      end
      extra = 0;
      repeat (hold) begin
         @(posedge clk); #1;
         if (read_ack === 1'b1) extra++;
      end
      if (hold > 0) begin
         checks++;
         if (extra != 0) begin
            errors++; $display("FAIL %s extra acks: got %0d want 0", nm, extra);
         end
      end
      read_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({read_ack, status_bus, src_req, src_addr, err_cnt} !== '0) begin
         errors++;
         $display("FAIL reset outputs: ack=%b bus=%h req=%b addr=%h err=%h want all 0",
                  read_ack, status_bus, src_req, src_addr, err_cnt);
      end
   endtask

   task automatic test_normal();
      src_word[2] = 32'h1234_5678; ack_dly[2] = 2;
      do_read(8'h25, 4'b0100, 4, 32'h1234_5678, 0, "normal");
   endtask

   task automatic test_back_to_back();
      src_word[3] = 32'hA5A5_0033; ack_dly[3] = 0;
      do_read(8'h3A, 4'b1000, 2, 32'hA5A5_0033, 0, "b2b_min");
      src_word[1] = 32'h0BAD_F00D; ack_dly[1] = 1;
      do_read(8'h11, 4'b0010, 3, 32'h0BAD_F00D, 0, "b2b_next");
   endtask

   task automatic test_decode_err();
      bump_err();
      do_read(8'h70, 4'b0000, 1, ERR, 0, "decode_err");
   endtask

   task automatic test_wrong_src();
      src_word[0] = 32'hC0DE_0000; src_word[3] = 32'h3333_3333; ack_dly[0] = 3;
      extra_ack = 4'b1000;
      do_read(8'h03, 4'b0001, 5, 32'hC0DE_0000, 0, "wrong_src");
      extra_ack = '0;
   endtask

   task automatic test_simul_ack();
      src_word[0] = 32'h5151_A0A0; ack_dly[0] = 7;
      do_read(8'h04, 4'b0001, 9, 32'h5151_A0A0, 0, "simul_ack");
   endtask

   task automatic test_hold_req();
      src_word[2] = 32'h0F0F_2222; ack_dly[2] = 1;
      do_read(8'h2F, 4'b0100, 3, 32'h0F0F_2222, 10, "hold_req");
   endtask

   task automatic test_reset_mid();
      ack_en[1] = 1'b0;
      uart_rd_addr = 8'h1C; read_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (src_req !== 4'b0010) begin
         errors++; $display("FAIL reset_mid wait src_req: got %b want 0010", src_req);
      end
      rst = 1'b1; read_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; model_err = 0;
      checks++;
      if ({read_ack, status_bus, src_req, src_addr, err_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid outputs: ack=%b bus=%h req=%b addr=%h err=%h want all 0",
                  read_ack, status_bus, src_req, src_addr, err_cnt);
      end
      ack_en[1] = 1'b1; src_word[1] = 32'h7777_1C1C; ack_dly[1] = 1;
      do_read(8'h1C, 4'b0010, 3, 32'h7777_1C1C, 0, "after_reset");
   endtask

   task automatic test_timeout();
      ack_en[1] = 1'b0;
`ifdef IPS2L_UART_STATUS_TIMEOUT_EN
      bump_err();
      do_read(8'h12, 4'b0010, 9, ERR, 0, "timeout");
`else
      begin
         int acks;
         acks = 0;
         uart_rd_addr = 8'h12; read_req = 1'b1;
         repeat (1000) begin
            @(posedge clk); #1;
            if (read_ack === 1'b1) acks++;
         end
         checks++;
         if (acks != 0) begin
            errors++; $display("FAIL no_timeout acks: got %0d want 0", acks);
         end
         checks++;
         if (src_req !== 4'b0010) begin
            errors++; $display("FAIL no_timeout src_req: got %b want 0010", src_req);
         end
         apply_reset();
      end
`endif
      ack_en[1] = 1'b1;
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         bump_err();
         do_read(8'hF0, 4'b0000, 1, ERR, 0, "saturate");
      end
      checks++;
      if (err_cnt !== 8'hFF) begin
         errors++; $display("FAIL saturate final err_cnt: got %h want ff", err_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin src_word[i] = '0; ack_dly[i] = 0; end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_normal();
      test_back_to_back();
      test_decode_err();
      test_wrong_src();
      test_simul_ack();
      test_hold_req();
      test_reset_mid();
      test_timeout();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end
endmodule
